// File: rtl/pipe_pkg.sv
// Shared definitions for CPU pipeline stage registers.
//   state_e             : occupancy of a skid-buffered stage (EMPTY/BUSY/FULL)
//   CTRL_BUBBLE_DEFAULT : control word that fires no downstream write enable
//   <STAGE>_DATA_W/_CTRL_W : standard payload widths per pipeline boundary
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int unsigned CTRL_BUBBLE_DEFAULT = 0;
  localparam int unsigned STALL_CNT_W         = 16;

  // IF/ID: PC + instruction
  localparam int unsigned IFID_DATA_W  = 64;
  localparam int unsigned IFID_CTRL_W  = 1;
  // ID/EX: PC + two operands + immediate
  localparam int unsigned IDEX_DATA_W  = 128;
  localparam int unsigned IDEX_CTRL_W  = 25;
  // EX/MEM: PC + ALU result + store data
  localparam int unsigned EXMEM_DATA_W = 96;
  localparam int unsigned EXMEM_CTRL_W = 25;
  // MEM/WB: load/ALU result + destination register
  localparam int unsigned MEMWB_DATA_W = 69;
  localparam int unsigned MEMWB_CTRL_W = 2;

  // Number of entries held in a given state.
  function automatic logic [1:0] state_count(input state_e s);
    case (s)
      BUSY:    state_count = 2'd1;
      FULL:    state_count = 2'd2;
      default: state_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; sticks at all-ones until RESET.
//   CLK   : clock
//   RESET : synchronous active-high clear
//   inc   : count this cycle
//   count : current value (registered)
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and one-entry skid buffer.
// O_READY comes straight from a register, so downstream back-pressure never
// reaches upstream combinationally.
//   CLK, RESET           : clock, synchronous active-high reset
//   I_VALID/I_DATA/I_CTRL: upstream entry;  O_READY: stage can accept
//   O_VALID/O_DATA/O_CTRL: head entry;      I_READY: downstream accepts
//   I_FLUSH              : squash everything held (and any same-cycle accept)
//   O_COUNT              : entries held (0..2)
//   O_STALL_CNT          : saturating count of cycles O_VALID & !I_READY
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W      = EXMEM_DATA_W,
  parameter int unsigned        CTRL_W      = EXMEM_CTRL_W,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEFAULT),
  parameter int unsigned        CNT_W       = STALL_CNT_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_VALID,
  output logic              O_READY,
  input  logic [DATA_W-1:0] I_DATA,
  input  logic [CTRL_W-1:0] I_CTRL,
  input  logic              I_FLUSH,
  output logic              O_VALID,
  input  logic              I_READY,
  output logic [DATA_W-1:0] O_DATA,
  output logic [CTRL_W-1:0] O_CTRL,
  output logic [1:0]        O_COUNT,
  output logic [CNT_W-1:0]  O_STALL_CNT
);

  state_e              r_state;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic                r_valid;
  logic                r_ready;
  logic [1:0]          r_count;
  logic [CTRL_W-1:0]   r_o_ctrl;

  state_e              w_state_nxt;
  logic [DATA_W-1:0]   w_main_data_nxt;
  logic [CTRL_W-1:0]   w_main_ctrl_nxt;
  logic [DATA_W-1:0]   w_skid_data_nxt;
  logic [CTRL_W-1:0]   w_skid_ctrl_nxt;
  logic                w_valid_nxt;
  logic                w_ready_nxt;
  logic [1:0]          w_count_nxt;
  logic [CTRL_W-1:0]   w_o_ctrl_nxt;
  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_stall;

  assign w_in_fire  = I_VALID & r_ready;
  assign w_out_fire = r_valid & I_READY;
  assign w_stall    = r_valid & ~I_READY;

  // Next-state and storage update; flush empties without touching data.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_data_nxt = r_main_data;
    w_main_ctrl_nxt = r_main_ctrl;
    w_skid_data_nxt = r_skid_data;
    w_skid_ctrl_nxt = r_skid_ctrl;

    if (I_FLUSH) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_main_data_nxt = I_DATA;
            w_main_ctrl_nxt = I_CTRL;
            w_state_nxt     = BUSY;
          end
        end
        BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_main_data_nxt = I_DATA;
            w_main_ctrl_nxt = I_CTRL;
          end else if (w_in_fire) begin
            w_skid_data_nxt = I_DATA;
            w_skid_ctrl_nxt = I_CTRL;
            w_state_nxt     = FULL;
          end else if (w_out_fire) begin
            w_state_nxt     = EMPTY;
          end
        end
        FULL: begin
          // O_READY is low here, so only the drain can happen.
          if (w_out_fire) begin
            w_main_data_nxt = r_skid_data;
            w_main_ctrl_nxt = r_skid_ctrl;
            w_state_nxt     = BUSY;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end

    // Outputs are precomputed from the next state so they come out of flops.
    w_valid_nxt  = (w_state_nxt != EMPTY);
    w_ready_nxt  = (w_state_nxt != FULL);
    w_count_nxt  = state_count(w_state_nxt);
    w_o_ctrl_nxt = w_valid_nxt ? w_main_ctrl_nxt : CTRL_BUBBLE;
  end

  // State, storage and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= CTRL_BUBBLE;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
      r_valid     <= 1'b0;
      r_ready     <= 1'b1;
      r_count     <= 2'd0;
      r_o_ctrl    <= CTRL_BUBBLE;
    end else begin
      r_state     <= w_state_nxt;
      r_main_data <= w_main_data_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_valid     <= w_valid_nxt;
      r_ready     <= w_ready_nxt;
      r_count     <= w_count_nxt;
      r_o_ctrl    <= w_o_ctrl_nxt;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (w_stall),
    .count (O_STALL_CNT)
  );

  assign O_READY = r_ready;
  assign O_VALID = r_valid;
  assign O_DATA  = r_main_data;
  assign O_CTRL  = r_o_ctrl;
  assign O_COUNT = r_count;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios followed by
// random valid/ready/flush/reset traffic, all checked against a queue model.
module tb_pipe_skid_stage;

  localparam int unsigned DW = 96;
  localparam int unsigned CW = 25;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          I_VALID;
  logic          I_FLUSH;
  logic          I_READY;
  logic [DW-1:0] I_DATA;
  logic [CW-1:0] I_CTRL;

  logic          o_ready, o_valid;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_ctrl;
  logic [1:0]    o_count;
  logic [15:0]   o_stall;

  logic          s_ready, s_valid;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_ctrl;
  logic [1:0]    s_count;
  logic [3:0]    s_stall;

  always #5 CLK = ~CLK;

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE('0), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .I_VALID(I_VALID), .O_READY(o_ready),
    .I_DATA(I_DATA), .I_CTRL(I_CTRL), .I_FLUSH(I_FLUSH), .O_VALID(o_valid),
    .I_READY(I_READY), .O_DATA(o_data), .O_CTRL(o_ctrl), .O_COUNT(o_count),
    .O_STALL_CNT(o_stall)
  );

  // Narrow stall counter copy, driven identically, to exercise saturation.
  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE('0), .CNT_W(4)) dut_sat (
    .CLK(CLK), .RESET(RESET), .I_VALID(I_VALID), .O_READY(s_ready),
    .I_DATA(I_DATA), .I_CTRL(I_CTRL), .I_FLUSH(I_FLUSH), .O_VALID(s_valid),
    .I_READY(I_READY), .O_DATA(s_data), .O_CTRL(s_ctrl), .O_COUNT(s_count),
    .O_STALL_CNT(s_stall)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] m_data;
  int unsigned   m_stall;
  int unsigned   m_stall4;
  bit            m_ready;
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most two entries with ready = room left.
  task automatic model_edge();
    bit mv;
    bit inf;
    bit outf;
    mv   = (q.size() > 0);
    inf  = I_VALID && m_ready;
    outf = mv && I_READY;
    if (RESET) begin
      q.delete();
      m_data   = '0;
      m_stall  = 0;
      m_stall4 = 0;
      m_ready  = 1'b1;
    end else begin
      if (mv && !I_READY) begin
        if (m_stall  < 65535) m_stall++;
        if (m_stall4 < 15)    m_stall4++;
      end
      if (I_FLUSH) begin
        q.delete();
      end else begin
        if (outf) void'(q.pop_front());
        if (inf)  q.push_back('{I_DATA, I_CTRL});
      end
      if (q.size() > 0) m_data = q[0].d;
      m_ready = (q.size() < 2);
    end
  endtask

  task automatic check_outputs();
    bit mv;
    mv = (q.size() > 0);
    chk("valid",  128'(o_valid), 128'(mv));
    chk("ready",  128'(o_ready), 128'(m_ready));
    chk("count",  128'(o_count), 128'(q.size()));
    chk("data",   128'(o_data),  128'(m_data));
    chk("ctrl",   128'(o_ctrl),  mv ? 128'(q[0].c) : 128'(0));
    chk("stall",  128'(o_stall), 128'(m_stall));
    chk("stall4", 128'(s_stall), 128'(m_stall4));
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs();
  endtask

  initial begin
    logic r0;
    RESET = 1'b1; I_VALID = 1'b0; I_FLUSH = 1'b0; I_READY = 1'b0;
    I_DATA = '0; I_CTRL = '0;
    m_ready = 1'b1; m_data = '0; m_stall = 0; m_stall4 = 0;

    // Reset values
    step();
    step();
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_ready", 128'(o_ready), 128'(1));
    chk("rst_count", 128'(o_count), 128'(0));
    chk("rst_data",  128'(o_data),  128'(0));
    chk("rst_ctrl",  128'(o_ctrl),  128'(0));
    chk("rst_stall", 128'(o_stall), 128'(0));
    RESET = 1'b0;

    // Stream 1..8 with downstream always ready
    I_READY = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      I_VALID = 1'b1; I_DATA = DW'(k); I_CTRL = CW'(k + 100);
      step();
      chk("stream_data",  128'(o_data),  128'(k));
      chk("stream_count", 128'(o_count), 128'(1));
    end
    I_VALID = 1'b0;
    step();
    chk("stream_stall", 128'(o_stall), 128'(0));

    // Back-pressure: A accepted, B goes to skid
    I_VALID = 1'b1; I_DATA = DW'('h11); I_CTRL = CW'(1);
    step();
    I_READY = 1'b0; I_DATA = DW'('h22); I_CTRL = CW'(2);
    step();
    chk("bp_count", 128'(o_count), 128'(2));
    chk("bp_ready", 128'(o_ready), 128'(0));
    chk("bp_head",  128'(o_data),  128'('h11));
    I_VALID = 1'b0;
    step();
    step();
    chk("bp_stall", 128'(o_stall), 128'(3));
    I_READY = 1'b1;
    step();
    chk("bp_second", 128'(o_data), 128'('h22));
    chk("bp_ready_back", 128'(o_ready), 128'(1));
    step();
    chk("bp_drained", 128'(o_valid), 128'(0));

    // Flush while FULL with a valid input presented
    I_READY = 1'b0; I_VALID = 1'b1; I_DATA = DW'('h0A); I_CTRL = CW'(3);
    step();
    I_DATA = DW'('h0B); I_CTRL = CW'(4);
    step();
    chk("pre_flush_count", 128'(o_count), 128'(2));
    I_FLUSH = 1'b1; I_DATA = DW'('h33); I_CTRL = CW'(5);
    step();
    I_FLUSH = 1'b0; I_VALID = 1'b0;
    chk("flush_valid", 128'(o_valid), 128'(0));
    chk("flush_ctrl",  128'(o_ctrl),  128'(0));
    chk("flush_count", 128'(o_count), 128'(0));
    chk("flush_ready", 128'(o_ready), 128'(1));
    chk("flush_keep",  128'(o_data),  128'('h0A));
    step();

    // Flush in BUSY, with an accept and a downstream transfer in the same cycle
    I_VALID = 1'b1; I_DATA = DW'('h55); I_CTRL = CW'(6);
    step();
    I_READY = 1'b1; I_FLUSH = 1'b1; I_DATA = DW'('h66);
    step();
    I_FLUSH = 1'b0; I_VALID = 1'b0;
    chk("flush_busy_valid", 128'(o_valid), 128'(0));
    chk("flush_busy_keep",  128'(o_data),  128'('h55));

    // Reset mid-stream while FULL
    I_READY = 1'b0; I_VALID = 1'b1; I_DATA = DW'('h71); I_CTRL = CW'(7);
    step();
    I_DATA = DW'('h72);
    step();
    chk("pre_rst_count", 128'(o_count), 128'(2));
    RESET = 1'b1; I_VALID = 1'b0;
    step();
    RESET = 1'b0;
    chk("mrst_valid", 128'(o_valid), 128'(0));
    chk("mrst_ready", 128'(o_ready), 128'(1));
    chk("mrst_count", 128'(o_count), 128'(0));
    chk("mrst_data",  128'(o_data),  128'(0));
    chk("mrst_stall", 128'(o_stall), 128'(0));
    I_VALID = 1'b1; I_READY = 1'b1; I_DATA = DW'('h44); I_CTRL = CW'(8);
    step();
    I_VALID = 1'b0;
    chk("post_rst_data",  128'(o_data),  128'('h44));
    chk("post_rst_count", 128'(o_count), 128'(1));
    step();
    chk("post_rst_alone", 128'(o_valid), 128'(0));

    // Saturation of the 4-bit stall counter
    I_VALID = 1'b1; I_DATA = DW'('h77); I_CTRL = CW'(9);
    step();
    I_VALID = 1'b0; I_READY = 1'b0;
    repeat (20) step();
    chk("sat4_stop",  128'(s_stall), 128'(15));
    chk("stall16_20", 128'(o_stall), 128'(20));
    I_READY = 1'b1;
    step();

    // Random traffic
    for (int n = 0; n < 10000; n++) begin
      RESET   = ($urandom_range(499) == 0);
      I_FLUSH = ($urandom_range(39) == 0);
      I_VALID = ($urandom_range(3) != 0);
      I_READY = ($urandom_range(2) != 0);
      I_DATA  = {$urandom, $urandom, $urandom};
      I_CTRL  = CW'($urandom);
      step();
      // O_READY must not follow a same-cycle change of I_READY
      r0 = o_ready;
      I_READY = ~I_READY;
      #1;
      chk("ready_indep", 128'(o_ready), 128'(r0));
      I_READY = ~I_READY;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register with valid/ready handshake, a one-entry skid buffer, synchronous flush and a saturating stall counter. It is the next generation of the fixed-width EX/MEM latch and is instantiated between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Back-pressure is absorbed without a combinational ready path. Flushed or empty slots present a bubble control word so that no downstream write enable fires.

## Interface
- DATA_W, 96: width of the datapath payload (e.g. PC + ALU result + write data).
- CTRL_W, 25: width of the control payload (e.g. regDst + control word).
- CTRL_BUBBLE, 0: control value driven on O_CTRL whenever O_VALID=0.
- CNT_W, 16: width of the stall counter.
- CLK  in  1  single clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- I_VALID  in  1  upstream holds a valid entry.
- O_READY  out  1  stage can accept an entry this cycle; registered.
- I_DATA  in  DATA_W  upstream payload.
- I_CTRL  in  CTRL_W  upstream control payload.
- I_FLUSH  in  1  discard all held entries (branch or exception squash).
- O_VALID  out  1  O_DATA/O_CTRL hold a valid entry.
- I_READY  in  1  downstream accepts the entry this cycle.
- O_DATA  out  DATA_W  payload of the head entry.
- O_CTRL  out  CTRL_W  control of the head entry; CTRL_BUBBLE when O_VALID=0.
- O_COUNT  out  2  entries held (0..2).
- O_STALL_CNT  out  CNT_W  saturating count of cycles with O_VALID=1 and I_READY=0.

## Operation
- Handshakes: in_fire = I_VALID & O_READY; out_fire = O_VALID & I_READY.
- Storage: main register (head, drives outputs) and skid register.
- States: EMPTY (0 entries), BUSY (main only), FULL (main + skid).
- EMPTY: in_fire loads main and goes to BUSY.
- BUSY:
  - in_fire & out_fire: main <= input, stay in BUSY.
  - in_fire & !out_fire: skid <= input, go to FULL.
  - !in_fire & out_fire: go to EMPTY.
- FULL: O_READY=0, so there is no in_fire. On out_fire, main <= skid and go to BUSY.
- O_READY = (state != FULL), taken from the registered state. There is no combinational path from I_READY to O_READY.
- Ordering: entries leave in acceptance order. No entry is lost or duplicated.
- Flush: I_FLUSH=1 forces EMPTY at the next edge.
  - An entry accepted in the same cycle is discarded.
  - Data registers keep their old contents; valids clear; O_CTRL becomes CTRL_BUBBLE.
  - A downstream out_fire in the flush cycle is still a legal transfer.
- Stall counter: increments each cycle O_VALID & !I_READY and saturates at all-ones. Flush does not clear it; only RESET does.
- Priority: RESET > I_FLUSH > handshake updates.

## Timing
- Latency: 1 cycle from in_fire to O_VALID/O_DATA.
- Throughput: 1 entry per cycle when I_READY is held high.
- Reset values (RESET high at an edge):
  - O_VALID=0, O_READY=1, O_COUNT=0, O_STALL_CNT=0.
  - O_DATA=0, O_CTRL=CTRL_BUBBLE; skid register=0.
- Reset mid-operation: both entries are dropped at that edge with no partial transfer. First acceptance is possible in the cycle after RESET falls.
- O_READY falls one cycle after the accept that fills the skid. It rises in the cycle after the out_fire that drains it.
- Simultaneous in_fire/out_fire in BUSY keeps O_COUNT constant at 1.
- O_COUNT changes in the same edge as the state transition.

## Structure
- Shared package pipe_pkg holds:
  - the state enum (EMPTY, BUSY, FULL);
  - the default CTRL_BUBBLE;
  - the standard DATA_W/CTRL_W values for each pipeline stage, so top-level instantiations reference named constants.
- One natural sub-module: sat_counter (parameter CNT_W; inputs CLK, RESET, inc; output count), reused by other performance counters.
- Main/skid storage and the FSM stay in pipe_skid_stage.

## Test plan
- Reset, then stream: hold I_READY=1 and send I_DATA=1..8 on consecutive cycles. O_DATA shows 1..8 one cycle later, O_COUNT stays 1, O_STALL_CNT=0.
- Back-pressure:
  - Accept A=0x11, then hold I_READY=0 and present B=0x22. Next cycle O_COUNT=2 and O_READY=0.
  - Release I_READY. O_DATA shows 0x11 then 0x22, and O_STALL_CNT equals the stalled cycles.
- Flush while FULL: assert I_FLUSH with I_VALID=1, C=0x33. Next cycle O_VALID=0, O_CTRL=CTRL_BUBBLE, O_COUNT=0, O_READY=1, and 0x33 never appears.
- Reset mid-stream: with O_COUNT=2, pulse RESET for one cycle. All outputs take their reset values at that edge. The next accepted entry, 0x44, appears alone.
- Saturation: with CNT_W=4 and I_READY held low for 20 cycles while O_VALID=1, O_STALL_CNT stops at 15.
- Random valid/ready (10k cycles, scoreboard): in-order, lossless, no duplicates. O_READY never depends on same-cycle I_READY.
